// File: rtl/fpu_pkg.sv
// Shared widths, opcodes and state encoding for the FPU operand sequencer.
package fpu_pkg;
    localparam int EXP_W      = 7;
    localparam int MAN_W      = 15;
    localparam int BUSY_LIMIT = 4;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LD1  = 3'b001;
    localparam logic [2:0] OP_LD2  = 3'b010;
    localparam logic [2:0] OP_LDM1 = 3'b011;
    localparam logic [2:0] OP_LDM2 = 3'b100;
    localparam logic [2:0] OP_STM  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    typedef struct packed {
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp_word_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_WRITEBACK
    } seq_state_e;
endpackage

// File: rtl/fpu_sequencer_if.sv
// Command port plus FPU-facing handshake of the sequencer.
interface fpu_sequencer_if #(parameter int AW = 3) ();
    import fpu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_addr;
    logic [EXP_W-1:0] cmd_e;
    logic [MAN_W-1:0] cmd_m;
    logic [EXP_W-1:0] r1_e;
    logic [MAN_W-1:0] r1_m;
    logic             done;
    logic             err;
    logic             fpu_add;
    logic             fpu_sub;
    logic [EXP_W-1:0] fpu_reg1_e;
    logic [MAN_W-1:0] fpu_reg1_m;
    logic [EXP_W-1:0] fpu_reg2_e;
    logic [MAN_W-1:0] fpu_reg2_m;
    logic [EXP_W-1:0] fpu_res_e;
    logic [MAN_W-1:0] fpu_res_m;
    logic             fpu_idle;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_e, cmd_m, fpu_res_e, fpu_res_m, fpu_idle,
        output cmd_ready, r1_e, r1_m, done, err, fpu_add, fpu_sub,
               fpu_reg1_e, fpu_reg1_m, fpu_reg2_e, fpu_reg2_m
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_e, cmd_m, fpu_res_e, fpu_res_m, fpu_idle,
        input  cmd_ready, r1_e, r1_m, done, err, fpu_add, fpu_sub,
               fpu_reg1_e, fpu_reg1_m, fpu_reg2_e, fpu_reg2_m
    );
endinterface

// File: rtl/fpu_word_mem.sv
// Operand memory: cleared on reset, written at the clock edge, read combinationally
// so a load sees a store made at the previous edge.
module fpu_word_mem
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fp_word_t      wdata,
    input  logic [AW-1:0] raddr,
    output fp_word_t      rdata
);
    fp_word_t mem_q [DEPTH];
    fp_word_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fpu_sequencer.sv
// Operand/accumulator controller in front of the add/sub FPU: loads, stores,
// issues ADD/SUB, follows the idle fall-then-rise handshake and writes back into R1.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 32
) (
    input logic            clk,
    input logic            reset,
    fpu_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    fp_word_t          r1_q, r1_d, r2_q, r2_d;
    logic              op_sub_q, op_sub_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_we;
    fp_word_t          mem_rdata;
    logic              fpu_add, fpu_sub, done;

    fpu_word_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (bus.cmd_addr),
        .wdata (r1_q),
        .raddr (bus.cmd_addr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        op_sub_d = op_sub_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        fpu_add  = 1'b0;
        fpu_sub  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                case (bus.cmd_op)
                    OP_LD1:  r1_d = '{e: bus.cmd_e, m: bus.cmd_m};
                    OP_LD2:  r2_d = '{e: bus.cmd_e, m: bus.cmd_m};
                    OP_LDM1: r1_d = mem_rdata;
                    OP_LDM2: r2_d = mem_rdata;
                    OP_STM:  mem_we = 1'b1;
                    OP_ADD, OP_SUB: begin
                        op_sub_d = (bus.cmd_op == OP_SUB);
                        state_d  = S_ISSUE;
                    end
                    default: ;
                endcase
            end
            S_ISSUE: begin
                fpu_add = !op_sub_q;
                fpu_sub = op_sub_q;
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            // The FPU must drop idle to acknowledge; otherwise the request was lost.
            S_WAIT_BUSY: begin
                if (!bus.fpu_idle) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.fpu_idle) begin
                    state_d = S_WRITEBACK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                done    = 1'b1;
                r1_d    = '{e: bus.fpu_res_e, m: bus.fpu_res_m};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            r1_q     <= '0;
            r2_q     <= '0;
            op_sub_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            op_sub_q <= op_sub_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.r1_e       = r1_q.e;
    assign bus.r1_m       = r1_q.m;
    assign bus.fpu_reg1_e = r1_q.e;
    assign bus.fpu_reg1_m = r1_q.m;
    assign bus.fpu_reg2_e = r2_q.e;
    assign bus.fpu_reg2_m = r2_q.m;
    assign bus.fpu_add    = fpu_add;
    assign bus.fpu_sub    = fpu_sub;
    assign bus.done       = done;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer with a behavioural add/sub FPU that can be
// made deaf (never drops idle) or hung (never raises idle again).
module tb_fpu_sequencer;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_sequencer_if #(.AW(3)) bus ();

    fpu_sequencer #(.DEPTH(8), .AW(3), .TIMEOUT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int rdy_miss = 0;
    int n_done, n_add, n_sub;
    logic order_ok, seen_low;
    logic dead = 1'b0;
    logic hang = 1'b0;

    function automatic logic [21:0] fmodel(input logic sub, input logic [6:0] ae, input logic [14:0] am,
                                           input logic [6:0] be, input logic [14:0] bm);
        int ea, eb, e;
        logic [15:0] ma, mb, r;
        logic [21:0] res;
        ea = int'($signed(ae));
        eb = int'($signed(be));
        if (ea >= eb) begin
            e = ea; ma = {1'b0, am}; mb = {1'b0, bm} >> (ea - eb);
        end else begin
            e = eb; ma = {1'b0, am} >> (eb - ea); mb = {1'b0, bm};
        end
        r = sub ? ma - mb : ma + mb;
        if (r[15] && !sub) begin r = r >> 1; e = e + 1; end
        for (int i = 0; i < 15; i++) if (r != 16'd0 && !r[14]) begin r = r << 1; e = e - 1; end
        res = {e[6:0], r[14:0]};
        return res;
    endfunction

    int mcnt;
    logic msub;
    logic [21:0] mop1, mop2;
    always @(posedge clk) begin
        if (reset) begin
            bus.fpu_idle  <= 1'b1;
            bus.fpu_res_e <= '0;
            bus.fpu_res_m <= '0;
            mcnt          <= 0;
        end else if ((bus.fpu_add || bus.fpu_sub) && !dead) begin
            bus.fpu_idle <= 1'b0;
            mcnt         <= hang ? 0 : 4;
            msub         <= bus.fpu_sub;
            mop1         <= {bus.fpu_reg1_e, bus.fpu_reg1_m};
            mop2         <= {bus.fpu_reg2_e, bus.fpu_reg2_m};
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt <= 0;
            bus.fpu_idle <= 1'b1;
            {bus.fpu_res_e, bus.fpu_res_m} <= fmodel(msub, mop1[21:15], mop1[14:0], mop2[21:15], mop2[14:0]);
        end else if (!hang) begin
            bus.fpu_idle <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] addr, input logic [6:0] e, input logic [14:0] m);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_e = e; bus.cmd_m = m;
        n = 0;
        if (!bus.cmd_ready) rdy_miss++;
        while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_op(input int cycles);
        n_done = 0; n_add = 0; n_sub = 0; order_ok = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.fpu_add) n_add++;
            if (bus.fpu_sub) n_sub++;
            if (!bus.fpu_idle) seen_low = 1'b1;
            if (bus.done) begin
                n_done++;
                if (seen_low && bus.fpu_idle) order_ok = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, last_done, early;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_addr = '0; bus.cmd_e = '0; bus.cmd_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_r1", 32'({bus.r1_e, bus.r1_m}), 32'd0);
        chk("rst_r2", 32'({bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'd0);
        chk("rst_err_done_add_sub", 32'({bus.err, bus.done, bus.fpu_add, bus.fpu_sub}), 32'd0);
        reset = 1'b0;

        // 1.0 + 1.0 = 2.0
        send(OP_LD1, 3'd0, 7'd0, 15'h4000);
        send(OP_LD2, 3'd0, 7'd0, 15'h4000);
        send(OP_ADD, 3'd0, 7'd0, 15'h0);
        run_op(20);
        chk("add_done_count", 32'(n_done), 32'd1);
        chk("add_pulse_count", 32'(n_add), 32'd1);
        chk("add_order", 32'(order_ok), 32'd1);
        chk("add_r1", 32'({bus.r1_e, bus.r1_m}), 32'({7'd1, 15'h4000}));
        chk("add_r2_kept", 32'({bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'({7'd0, 15'h4000}));

        // 3.0 - 1.0 = 2.0
        send(OP_LD1, 3'd0, 7'd1, 15'h6000);
        send(OP_LD2, 3'd0, 7'd0, 15'h4000);
        send(OP_SUB, 3'd0, 7'd0, 15'h0);
        run_op(20);
        chk("sub_pulse_count", 32'(n_sub), 32'd1);
        chk("sub_no_add", 32'(n_add), 32'd0);
        chk("sub_done_count", 32'(n_done), 32'd1);
        chk("sub_r1", 32'({bus.r1_e, bus.r1_m}), 32'({7'd1, 15'h4000}));

        // Store then immediately reload, back to back
        rdy_miss = 0;
        send(OP_LD1, 3'd0, 7'd2, 15'h5000);
        send(OP_STM, 3'd3, 7'd0, 15'h0);
        send(OP_LD1, 3'd0, 7'd0, 15'h0);
        send(OP_LDM1, 3'd3, 7'd0, 15'h0);
        @(negedge clk);
        chk("ldm1_r1", 32'({bus.r1_e, bus.r1_m}), 32'({7'd2, 15'h5000}));
        send(OP_LDM2, 3'd3, 7'd0, 15'h0);
        send(OP_NOP, 3'd0, 7'd0, 15'h0);
        @(negedge clk);
        chk("ldm2_r2", 32'({bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'({7'd2, 15'h5000}));
        chk("ldst_ready_held", 32'(rdy_miss), 32'd0);
        chk("ldst_ready_now", 32'(bus.cmd_ready), 32'd1);

        // FPU never acknowledges: abort after four WAIT_BUSY cycles
        dead = 1'b1;
        send(OP_LD1, 3'd0, 7'd3, 15'h4800);
        send(OP_ADD, 3'd0, 7'd0, 15'h0);
        repeat (5) @(negedge clk);
        chk("busy_to_still_busy", 32'({bus.cmd_ready, bus.err}), 32'd0);
        @(negedge clk);
        chk("busy_to_err", 32'(bus.err), 32'd1);
        chk("busy_to_ready", 32'(bus.cmd_ready), 32'd1);
        chk("busy_to_r1", 32'({bus.r1_e, bus.r1_m}), 32'({7'd3, 15'h4800}));
        dead = 1'b0;

        // FPU acknowledges but never finishes: WAIT_DONE timeout
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst2_err", 32'(bus.err), 32'd0);
        hang = 1'b1;
        send(OP_LD1, 3'd0, 7'd1, 15'h4000);
        send(OP_ADD, 3'd0, 7'd0, 15'h0);
        repeat (20) @(negedge clk);
        chk("hang_waiting", 32'({bus.cmd_ready, bus.err}), 32'd0);
        repeat (20) @(negedge clk);
        chk("hang_err", 32'(bus.err), 32'd1);
        chk("hang_ready", 32'(bus.cmd_ready), 32'd1);
        chk("hang_r1", 32'({bus.r1_e, bus.r1_m}), 32'({7'd1, 15'h4000}));
        hang = 1'b0;
        repeat (2) @(negedge clk);

        // Command held off while an ADD is in flight
        send(OP_LD2, 3'd0, 7'd0, 15'h4000);
        send(OP_ADD, 3'd0, 7'd0, 15'h0);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_LD2; bus.cmd_e = 7'd5; bus.cmd_m = 15'h1234;
        last_done = -10; early = 0; k = 0;
        while (!bus.cmd_ready && k < 40) begin
            if (bus.done) last_done = k;
            if ({bus.fpu_reg2_e, bus.fpu_reg2_m} !== {7'd0, 15'h4000}) early++;
            @(negedge clk);
            k++;
        end
        chk("hold_ready", 32'(bus.cmd_ready), 32'd1);
        chk("hold_after_done", 32'(last_done), 32'(k - 1));
        chk("hold_r2_not_early", 32'(early), 32'd0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold_r2_loaded", 32'({bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'({7'd5, 15'h1234}));

        // Reset in the middle of WAIT_DONE (err is still set from the timeout)
        send(OP_ADD, 3'd0, 7'd0, 15'h0);
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'({bus.cmd_ready, bus.fpu_idle}), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_r1", 32'({bus.r1_e, bus.r1_m}), 32'd0);
        chk("mid_rst_r2", 32'({bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'd0);
        chk("mid_rst_err", 32'(bus.err), 32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_add", 32'({bus.fpu_add, bus.fpu_sub, bus.done}), 32'd0);
        @(negedge clk); reset = 1'b0;
        send(OP_LDM1, 3'd3, 7'd0, 15'h0);
        @(negedge clk);
        chk("mid_rst_mem", 32'({bus.r1_e, bus.r1_m}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
